// File: rtl/axi_lite_sram_pkg.sv
// ============================================================================
// Module      : axi_lite_sram_pkg
// Description : Shared definitions for the AXI-Lite SRAM responder.
//               Supplies the datapath width `CPU_WIDTH` (default 32 when the
//               build does not define it), the AXI response codes, the delay
//               counter width and the read/write FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package axi_lite_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Response delay is 0..15 extra cycles in both fixed and random modes.
  localparam int DLY_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_sram_delay_lfsr.sv
// ============================================================================
// Module      : delay_lfsr
// Description : 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
//               Advances every clock; loads SEED on reset.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               lfsr  - current 8-bit LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_lfsr #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  // Taps 8,6,5,4 map to state bits 7,5,4,3; shift towards the MSB.
  logic feedback;
  assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_sram.sv
// ============================================================================
// Module      : axi_lite_sram
// Description : AXI-Lite responder backed by a word-addressed register array.
//               Independent read and write engines, one transaction each in
//               flight, responses after a programmable delay D.
//               Build macro AXIL_SRAM_RAND_DELAY_EN: when defined, D is taken
//               from lfsr[3:0] of a free-running delay_lfsr (FIXED_DELAY is
//               ignored); otherwise D = FIXED_DELAY.
// Ports       : i_clk, i_rst         - clock, async active-high reset
//               s_aw*, s_w*, s_b*    - write address / data / response
//               s_ar*, s_r*          - read address / data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module axi_lite_sram #(
  parameter int                      DEPTH       = 1024,
  parameter logic [`CPU_WIDTH-1:0]   BASE_ADDR   = 32'h8000_0000,
  parameter int                      FIXED_DELAY = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [`CPU_WIDTH-1:0]      s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [`CPU_WIDTH-1:0]      s_wdata,
  input  logic [`CPU_WIDTH/8-1:0]    s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [`CPU_WIDTH-1:0]      s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [`CPU_WIDTH-1:0]      s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready
);

  import axi_lite_sram_pkg::*;

  localparam int            W       = `CPU_WIDTH;
  localparam int            NB      = W / 8;
  localparam int            OFF     = $clog2(NB);
  localparam int            IDX_W   = $clog2(DEPTH);
  localparam logic [W-1:0]  DEPTH_W = W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Response delay source
  // ---------------------------------------------------------------------------
  logic [DLY_W-1:0] dly;

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_state;
  logic       unused_lfsr_hi;
  localparam int unused_fixed_delay = FIXED_DELAY;

  delay_lfsr #(
    .SEED (8'h5A)
  ) u_delay_lfsr (
    .clk  (i_clk),
    .rst  (i_rst),
    .lfsr (lfsr_state)
  );

  assign dly            = lfsr_state[DLY_W-1:0];
  assign unused_lfsr_hi = ^lfsr_state[7:DLY_W];
`else
  assign dly = DLY_W'(FIXED_DELAY);
`endif

  // ---------------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode of the latched read/write addresses. The subtraction wraps
  // for addresses below BASE_ADDR, so the lower bound is checked explicitly.
  // ---------------------------------------------------------------------------
  logic [W-1:0]     rd_addr, wr_addr;
  logic [W-1:0]     rd_off,  wr_off;
  logic             rd_ok,   wr_ok;
  logic [IDX_W-1:0] rd_idx,  wr_idx;

  assign rd_off = rd_addr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_ok  = (rd_addr >= BASE_ADDR) && ((rd_off >> OFF) < DEPTH_W);
  assign wr_ok  = (wr_addr >= BASE_ADDR) && ((wr_off >> OFF) < DEPTH_W);
  assign rd_idx = rd_off[OFF +: IDX_W];
  assign wr_idx = wr_off[OFF +: IDX_W];

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rd_state_t        rd_state;
  logic [DLY_W-1:0] rd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_state  <= R_IDLE;
      rd_cnt    <= '0;
      rd_addr   <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            rd_addr   <= s_araddr;
            rd_cnt    <= dly;
            s_arready <= 1'b0;
            rd_state  <= R_WAIT;
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (rd_cnt == '0) begin
            // Non-blocking sample: a write committing on this same edge is
            // not yet visible, so a colliding read returns the old word.
            s_rdata  <= rd_ok ? mem[rd_idx] : '0;
            s_rresp  <= rd_ok ? RESP_OKAY : RESP_DECERR;
            s_rvalid <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  wr_state_t        wr_state;
  logic [DLY_W-1:0] wr_cnt;
  logic [W-1:0]     wr_data;
  logic [NB-1:0]    wr_strb;
  logic             have_aw, have_w;
  logic             aw_hs, w_hs, aw_done, w_done;
  logic             wr_commit;

  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign aw_done   = have_aw || aw_hs;
  assign w_done    = have_w || w_hs;
  assign wr_commit = (wr_state == W_WAIT) && (wr_cnt == '0) && wr_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_state  <= W_IDLE;
      wr_cnt    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      have_aw   <= 1'b0;
      have_w    <= 1'b0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr <= s_awaddr;
            have_aw <= 1'b1;
          end
          if (w_hs) begin
            wr_data <= s_wdata;
            wr_strb <= s_wstrb;
            have_w  <= 1'b1;
          end
          if (aw_done && w_done) begin
            wr_cnt    <= dly;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            wr_state  <= W_WAIT;
          end else begin
            // Each channel stays closed once its beat has been captured.
            s_awready <= !aw_done;
            s_wready  <= !w_done;
          end
        end
        W_WAIT: begin
          if (wr_cnt == '0) begin
            s_bresp  <= wr_ok ? RESP_OKAY : RESP_DECERR;
            s_bvalid <= 1'b1;
            wr_state <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - 1'b1;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Commit is gated by the reset-cleared write state, so a reset during
  // W_WAIT leaves the array untouched.
  always_ff @(posedge i_clk) begin
    if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
